// File: rtl/gb_irq_pkg.sv
// Shared constants for the Game Boy style interrupt controller:
// source bit indices, vectors, default register addresses and FSM states.
package gb_irq_pkg;

    localparam logic [2:0] SRC_VBLANK = 3'd0;
    localparam logic [2:0] SRC_STAT   = 3'd1;
    localparam logic [2:0] SRC_TIMER  = 3'd2;
    localparam logic [2:0] SRC_SERIAL = 3'd3;
    localparam logic [2:0] SRC_JOYPAD = 3'd4;

    localparam logic [15:0] VEC_VBLANK = 16'h0040;
    localparam logic [15:0] VEC_STAT   = 16'h0048;
    localparam logic [15:0] VEC_TIMER  = 16'h0050;
    localparam logic [15:0] VEC_SERIAL = 16'h0058;
    localparam logic [15:0] VEC_JOYPAD = 16'h0060;

    localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [15:0] vec_of(input logic [2:0] idx);
        logic [15:0] v;
        v = VEC_VBLANK;
        case (idx)
            SRC_VBLANK: v = VEC_VBLANK;
            SRC_STAT:   v = VEC_STAT;
            SRC_TIMER:  v = VEC_TIMER;
            SRC_SERIAL: v = VEC_SERIAL;
            SRC_JOYPAD: v = VEC_JOYPAD;
            default:    v = VEC_VBLANK;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/gb_irq_prio.sv
// Combinational 5-bit priority encoder; the lowest set bit wins.
module gb_irq_prio (
    input  logic [4:0] pending,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |pending;
        idx   = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/gb_irq.sv
// Interrupt controller with IF/IE registers and an IDLE/REQ/HOLD request FSM.
// Define GB_IRQ_EDGE_EN to set IF on rising edges of irq_src instead of levels.
module gb_irq
    import gb_irq_pkg::*;
#(
    parameter logic [15:0] IF_ADDR = IF_ADDR_DEF,
    parameter logic [15:0] IE_ADDR = IE_ADDR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    input  logic [4:0]  irq_src,
    output logic        intreq,
    output logic [15:0] intaddress,
    input  logic        intack
);

    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        intreq_q, intreq_d;
    logic [15:0] vec_q, vec_d;

    logic [4:0]  set;
    logic [4:0]  pending;
    logic [4:0]  idx_mask;
    logic        ack;
    logic        prio_valid;
    logic [2:0]  prio_idx;

`ifdef GB_IRQ_EDGE_EN
    logic [4:0] src_q, src_d;

    assign src_d = irq_src;
    assign set   = irq_src & ~src_q;

    always_ff @(posedge clock) begin
        if (reset) src_q <= 5'd0;
        else       src_q <= src_d;
    end
`else
    assign set = irq_src;
`endif

    assign pending  = if_q & ie_q[4:0];
    assign idx_mask = 5'b00001 << idx_q;
    assign ack      = (state_q == ST_REQ) && intack;

    gb_irq_prio u_prio (
        .pending (pending),
        .valid   (prio_valid),
        .idx     (prio_idx)
    );

    // Ack clear, then CPU write, then source set: a new set always survives.
    always_comb begin
        if_d = if_q;
        if (ack) if_d = if_d & ~idx_mask;
        if (store && address == IF_ADDR) if_d = indata[4:0];
        if_d = if_d | set;

        ie_d = ie_q;
        if (store && address == IE_ADDR) ie_d = indata;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (prio_valid) begin
                    state_d = ST_REQ;
                    idx_d   = prio_idx;
                end
            end
            ST_REQ: begin
                if (intack)                        state_d = ST_HOLD;
                else if (~|(pending & idx_mask))   state_d = ST_IDLE;
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        intreq_d = (state_d == ST_REQ);
        vec_d    = intreq_d ? vec_of(idx_d) : 16'h0000;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if_q     <= 5'd0;
            ie_q     <= 8'd0;
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            intreq_q <= 1'b0;
            vec_q    <= 16'h0000;
        end else begin
            if_q     <= if_d;
            ie_q     <= ie_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            intreq_q <= intreq_d;
            vec_q    <= vec_d;
        end
    end

    always_comb begin
        outdata = 8'h00;
        if (load && address == IF_ADDR)      outdata = {3'b111, if_q};
        else if (load && address == IE_ADDR) outdata = ie_q;
    end

    assign intreq     = intreq_q;
    assign intaddress = vec_q;

endmodule

// File: doc/gb_irq.md
GB_IRQ -- requirements
Module: gb_irq

Interface
REQ-001 SHALL have parameter IF_ADDR, default 16'hFF0F, address of the interrupt flag register.
REQ-002 SHALL have parameter IE_ADDR, default 16'hFFFF, address of the interrupt enable register.
REQ-003 SHALL have port clock  in  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port address  in  16  CPU bus address.
REQ-006 SHALL have port indata  in  8  CPU write data.
REQ-007 SHALL have port outdata  out  8  register read data.
REQ-008 SHALL have port load  in  1  CPU read strobe.
REQ-009 SHALL have port store  in  1  CPU write strobe.
REQ-010 SHALL have port irq_src  in  5  source lines: bit 0 vblank, bit 1 lcd stat, bit 2 timer, bit 3 serial, bit 4 joypad.
REQ-011 SHALL have port intreq  out  1  interrupt request to the CPU.
REQ-012 SHALL have port intaddress  out  16  vector of the presented interrupt.
REQ-013 SHALL have port intack  in  1  one-cycle CPU acknowledge of the presented vector.

Function
REQ-014 SHALL hold IF (5 bits) and IE (8 bits); pending = IF & IE[4:0].
REQ-015 SHALL map vectors bit0..4 -> 16'h0040, 0048, 0050, 0058, 0060; priority is lowest bit first.
REQ-016 SHALL read combinationally: load and address==IF_ADDR -> {3'b111,IF}; load and address==IE_ADDR -> IE; otherwise 8'h00.
REQ-017 SHALL write on store: IF <= indata[4:0], IE <= indata, taking effect next cycle.
REQ-018 SHALL OR a same-cycle source set into IF after the CPU write; the set wins.
REQ-019 SHALL implement FSM IDLE/REQ/HOLD with registered state and registered latched vector index.
REQ-020 IDLE: when pending is nonzero, latch the highest-priority index and go to REQ; intreq=0.
REQ-021 REQ: intreq=1 and intaddress = vector of the latched index; the vector SHALL stay stable while in REQ even if a higher-priority bit arrives.
REQ-022 REQ with intack: clear IF[latched] and go to HOLD; a same-cycle source set of that bit SHALL win and leave it set.
REQ-023 REQ without intack and pending[latched]==0 (e.g. cleared by a CPU write): go to IDLE with intreq deasserted next cycle.
REQ-024 HOLD: intreq=0 for exactly one cycle, then IDLE; intack outside REQ SHALL be ignored.
REQ-025 intaddress SHALL be 16'h0000 whenever intreq=0.
REQ-026 Request latency: a source set at edge N gives intreq=1 after edge N+2 (IF update, then IDLE->REQ).

Reset
REQ-027 On reset: IF=0, IE=0, state=IDLE, latched index=0, intreq=0, intaddress=0, edge history=0.
REQ-028 Reset asserted in REQ or HOLD SHALL abort to IDLE next cycle without clearing any pending acknowledge side effect beyond REQ-027.

Configuration
REQ-029 GB_IRQ_EDGE_EN defined: IF bit set on a rising edge of irq_src (registered previous value); a held-high source sets once.
REQ-030 GB_IRQ_EDGE_EN undefined: IF bit set every cycle irq_src bit is 1 (sources deliver one-cycle pulses); no history register.

Structure
REQ-031 Package gb_irq_pkg SHALL hold source bit indices, vector constants, default register addresses and FSM state encoding.
REQ-032 Sub-module gb_irq_prio SHALL be the combinational 5-bit priority encoder (pending -> valid, index).

Verification
REQ-033 Write IE=8'h04; pulse irq_src=5'b00100 -> intreq=1 two cycles later, intaddress=16'h0050; read IF_ADDR -> 8'hE4.
REQ-034 IE=8'h1F; IF=5'b10001 set in one cycle -> vector 16'h0040; intack -> HOLD for one cycle, then vector 16'h0060 and IF reads 8'hF0.
REQ-035 In REQ with vector 16'h0058, raise bit 0 -> vector stays 16'h0058 until intack.
REQ-036 In REQ for timer, write IF=8'h00 -> intreq=0 next cycle and state returns to IDLE.
REQ-037 intack together with a timer source pulse in REQ(timer) -> IF[2] stays 1, intreq re-asserts after HOLD.
REQ-038 With GB_IRQ_EDGE_EN, hold irq_src[0]=1 for 10 cycles; ack once -> no second request; also assert reset in REQ -> intreq=0, IE=0 next cycle.
